// File: rtl/jpeg_byte_unpacker.sv
// jpeg_byte_unpacker: 128-bit JPEG entropy words in, 0xFF00-unstuffed 64-bit beats out.
// Define JPEG_BYTE_UNPACKER_MARKER_EN to strip RST/EOI markers onto the marker sideband.
module jpeg_byte_unpacker #(
  parameter int SIZE_W = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [127:0]      in_data,
  input  logic [4:0]        in_bytes,
  input  logic              in_tlast,
  input  logic              in_valid,
  output logic              in_hold,
  output logic [63:0]       out_data,
  output logic [3:0]        out_bytes,
  output logic              out_tlast,
  output logic              out_valid,
  input  logic              out_hold,
  output logic [7:0]        marker,
  output logic              marker_valid,
  output logic [SIZE_W-1:0] size
);

  logic [127:0]      r_buf;
  logic [4:0]        r_cnt;
  logic [4:0]        r_rd;
  logic              r_tl;
  logic              r_pend;
  logic              r_ov;
  logic [63:0]       r_od;
  logic [3:0]        r_ob;
  logic              r_otl;
  logic [7:0]        r_mk;
  logic              r_mkv;
  logic [SIZE_W-1:0] r_size;

  logic [4:0]   w_rem;
  logic         w_have;
  logic         w_adv;
  logic         w_xfer;
  logic         w_acc;
  logic [127:0] w_sh;
  logic [127:0] w_lw;
  logic [3:0]   w_raw;
  logic [3:0]   w_wn;
  logic         w_fin;
  logic [7:0]   w_win [9];
  logic [7:0]   w_ob [8];
  logic [3:0]   w_n;
  logic [3:0]   w_cons;
  logic         w_setp;
  logic         w_stop;
  logic         w_skip;
  logic         w_mkv;
  logic         w_eoi;
  logic [7:0]   w_mk;
  logic [4:0]   w_rc;
  logic [4:0]   w_nrd;
  logic         w_tl;
  logic         w_emit;
  logic         w_last;
  logic [63:0]  w_pk;

  assign w_rem  = r_cnt - r_rd;
  assign w_have = (w_rem != 5'd0);
  assign w_xfer = r_ov & ~out_hold;
  assign w_adv  = w_have & (~r_ov | ~out_hold);
  assign w_sh   = r_buf << {r_rd, 3'b000};
  // a held-back 0xFF is replayed as logical byte 0 of the window
  assign w_lw   = r_pend ? {8'hFF, w_sh[127:8]} : w_sh;

  always_comb begin
    if (r_pend) w_raw = (w_rem > 5'd7) ? 4'd7 : w_rem[3:0];
    else        w_raw = (w_rem > 5'd8) ? 4'd8 : w_rem[3:0];
  end

  assign w_wn  = w_raw + {3'd0, r_pend};
  assign w_fin = r_tl & ({1'b0, w_raw} == w_rem);

  always_comb begin
    for (int k = 0; k < 8; k++) w_win[k] = w_lw[127-8*k -: 8];
    w_win[8] = 8'h00;
  end

  always_comb begin
    w_n    = 4'd0;
    w_cons = 4'd0;
    w_setp = 1'b0;
    w_stop = 1'b0;
    w_skip = 1'b0;
    w_mkv  = 1'b0;
    w_eoi  = 1'b0;
    w_mk   = 8'h00;
    for (int k = 0; k < 8; k++) w_ob[k] = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (!w_stop && (4'(k) < w_wn)) begin
        if (w_skip) begin
          w_skip = 1'b0;
        end else if (w_win[k] == 8'hFF) begin
          if (4'(k + 1) < w_wn) begin
            if (w_win[k+1] == 8'h00) begin
              w_ob[w_n[2:0]] = 8'hFF;
              w_n = w_n + 4'd1;
              w_skip = 1'b1;
            end
`ifdef JPEG_BYTE_UNPACKER_MARKER_EN
            else if (w_win[k+1][7:3] == 5'b11010 ||
                     w_win[k+1] == 8'hD9) begin
              w_mkv  = 1'b1;
              w_mk   = w_win[k+1];
              w_eoi  = (w_win[k+1] == 8'hD9);
              w_stop = 1'b1;
              w_cons = 4'(k + 2);
            end
`endif
            else begin
              w_ob[w_n[2:0]] = 8'hFF;
              w_n = w_n + 4'd1;
            end
          end else if (w_fin) begin
            w_ob[w_n[2:0]] = 8'hFF;
            w_n = w_n + 4'd1;
          end else begin
            w_setp = 1'b1;
          end
        end else begin
          w_ob[w_n[2:0]] = w_win[k];
          w_n = w_n + 4'd1;
        end
        if (!w_stop) w_cons = 4'(k + 1);
      end
    end
  end

  assign w_rc   = w_stop ? {1'b0, w_cons - {3'd0, r_pend}}
                         : {1'b0, w_raw};
  assign w_nrd  = w_eoi ? r_cnt : r_rd + w_rc;
  assign w_tl   = (r_tl & (w_nrd == r_cnt)) | w_eoi;
  assign w_emit = (w_n != 4'd0) | w_tl | w_mkv;
  assign w_last = w_adv & (w_nrd == r_cnt);
  assign w_pk   = {w_ob[0], w_ob[1], w_ob[2], w_ob[3],
                   w_ob[4], w_ob[5], w_ob[6], w_ob[7]};

  assign in_hold = out_hold | (w_have & ~w_last);
  assign w_acc   = in_valid & ~in_hold;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_buf  <= '0;
      r_cnt  <= '0;
      r_rd   <= '0;
      r_tl   <= 1'b0;
      r_pend <= 1'b0;
      r_ov   <= 1'b0;
      r_od   <= '0;
      r_ob   <= '0;
      r_otl  <= 1'b0;
      r_mk   <= '0;
      r_mkv  <= 1'b0;
      r_size <= '0;
    end else begin
      if (w_acc) begin
        r_buf <= in_data;
        r_cnt <= in_bytes;
        r_rd  <= '0;
        r_tl  <= in_tlast;
      end else if (w_adv) begin
        r_rd  <= w_nrd;
      end
      if (w_adv) begin
        r_pend <= w_setp & ~w_tl;
        r_ov   <= w_emit;
        if (w_emit) begin
          r_od  <= w_pk;
          r_ob  <= w_n;
          r_otl <= w_tl;
          r_mk  <= w_mk;
          r_mkv <= w_mkv;
        end
      end else if (w_xfer) begin
        r_ov <= 1'b0;
      end
      if (w_xfer) r_size <= r_otl ? '0 : r_size + SIZE_W'(r_ob);
    end
  end

  assign out_data     = r_od;
  assign out_bytes    = r_ob;
  assign out_tlast    = r_otl;
  assign out_valid    = r_ov;
  assign marker       = r_mk;
  assign marker_valid = r_mkv;
  // the beat sitting in the output register already counts as emitted
  assign size = r_size + (r_ov ? SIZE_W'(r_ob) : '0);

endmodule

// File: doc/jpeg_byte_unpacker.md
Name: jpeg_byte_unpacker

Overview:
- Decoder-side counterpart of the JPEG encoder byte packer.
- Accepts 128-bit MSB-first JPEG entropy-coded words and removes 0xFF00 byte stuffing, including stuffing split across chunk or word boundaries.
- Re-emits the stream as 64-bit MSB-first beats with a byte count, for the decoder bit unpacker / Huffman front end.
- Optionally strips RST/EOI markers and reports them on a sideband.

Parameters:
- SIZE_W, 20, width of the emitted-byte counter `size`.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- in_data  in  128  stream bytes, byte 0 at [127:120]; only the top in_bytes bytes are valid
- in_bytes  in  5  valid byte count, 1..16
- in_tlast  in  1  last word of scan
- in_valid  in  1  input word present
- in_hold  out  1  upstream must hold word stable
- out_data  out  64  unstuffed bytes, byte 0 at [63:56]; unused low bytes are 0
- out_bytes  out  4  valid bytes in beat, 0..8 (0 only with out_tlast or marker_valid)
- out_tlast  out  1  last beat of scan
- out_valid  out  1  beat present
- out_hold  in  1  downstream backpressure
- marker  out  8  marker code (second marker byte); 0 when marker_valid=0
- marker_valid  out  1  marker qualifies this beat
- size  out  SIZE_W  total bytes emitted since reset; cleared after the tlast beat transfers

Behaviour:
- Input transfer: in_valid & ~in_hold. Output transfer: out_valid & ~out_hold.
- Output stability: out_data, out_bytes, out_tlast, marker and marker_valid stay stable while out_valid & out_hold.
- Buffer: one 16-byte word register plus a read pointer rd_ptr (0..16).
- in_hold (combinational) = out_hold | (buffer non-empty & the current chunk does not consume the final buffered byte).
  - A word is accepted in the same cycle its predecessor's last chunk is consumed, so there are no bubbles.
- Chunk step: one per cycle when the output register is empty or transferring.
  - Window = next 8 raw bytes, or 7 when pending_ff=1 so that a beat never exceeds 8 bytes.
  - Byte 0xFF followed by 0x00 inside the window: emit 0xFF, drop 0x00.
  - 0xFF in the last window position, with the next raw byte not yet visible: hold it back and set pending_ff.
  - Next chunk with pending_ff=1 and first raw byte 0x00: emit 0xFF, drop the 0x00, clear pending_ff.
  - Next chunk with pending_ff=1 and first raw byte non-zero: emit 0xFF, then process that byte normally.
  - pending_ff persists across input words.
- Latency: first beat has out_valid=1 two cycles after input acceptance (buffer load, then output register).
- A chunk yielding 0 bytes (for example only the stuffed 0x00) produces no beat, unless it carries tlast or a marker.
- tlast: out_tlast=1 on the beat that consumes the final raw byte of the in_tlast word.
  - A pending_ff at tlast is emitted as a data byte on that beat.
  - pending_ff is cleared after the tlast beat.
- size: at each transfer, size += out_bytes. Arithmetic is modulo 2^SIZE_W.
- Reset: out_valid=0, out_data=0, out_bytes=0, out_tlast=0, marker=0, marker_valid=0, size=0, buffer empty, rd_ptr=0, pending_ff=0, in_hold=out_hold.
- Reset mid-scan discards all buffered and in-flight data.
- Simultaneous new input and output transfer in the same cycle is legal. Input with in_valid=0 leaves state unchanged.

Optional Feature:
- Macro: JPEG_BYTE_UNPACKER_MARKER_EN.
- Defined:
  - 0xFF followed by 0xD0..0xD7 (RST) or 0xD9 (EOI) terminates the current beat before the 0xFF.
  - Both marker bytes are consumed and not emitted.
  - That beat carries marker_valid=1 and marker = the code; out_bytes may be 0.
  - Raw bytes after the marker start the next chunk.
  - EOI also forces out_tlast=1 on that beat; remaining bytes of the word are discarded.
  - Other 0xFF xx pairs (xx≠00) pass through unchanged.
- Undefined:
  - Only 0xFF00 unstuffing is performed; all other 0xFF xx pairs pass through unchanged.
  - marker and marker_valid are tied to 0.

Test Plan:
- Word 16 bytes 00..0F, tlast=1 -> beats {00..07, bytes=8}, then {08..0F, bytes=8, tlast=1}; size resets to 0 after the tlast beat; size=16 before it transfers.
- Word 12 34 FF 00 56 (bytes=5, tlast=1) -> single beat 12 34 FF 56, bytes=4, tlast=1.
- Word A ends ...FF (bytes=16), word B starts 00 77 -> FF emitted once, 00 dropped, 77 follows; no beat exceeds 8 bytes.
- out_hold held high 10 cycles mid-scan -> out_data and out_bytes stable; in_hold=1; no bytes lost or duplicated after release.
- MARKER_EN: 11 22 FF D3 33 FF D9 (tlast=1) -> {11 22, marker_valid=1, marker=D3}, then {33, marker_valid=1, marker=D9, tlast=1}.
- resetn low mid-scan, then fresh word AA BB (tlast=1) -> exactly one beat AA BB, bytes=2, tlast=1; size=2 before it transfers.
